// File: rtl/stereo_seq_pkg.sv
// Shared types and default widths for the stereo LBM frame sequencer.
package stereo_seq_pkg;

  localparam int unsigned DEF_NUM_PROC = 6;
  localparam int unsigned DEF_WDOG_W   = 20;
  localparam int unsigned DEF_FRAME_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StHalt
  } seq_state_e;

endpackage

// File: rtl/stereo_frame_sequencer_if.sv
// Control/handshake bundle between system control, the sequencer and the LBM core.
// max_frame_cycles exists only when STEREO_SEQ_STATS_EN is defined.
interface stereo_frame_sequencer_if #(
  parameter int unsigned NUM_PROC = 6,
  parameter int unsigned WDOG_W   = 20,
  parameter int unsigned FRAME_W  = 16
);
  localparam int unsigned IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

  logic                run;
  logic                frame_req;
  logic [WDOG_W-1:0]   wdog_limit;
  logic                clear_dl;
  logic                ap_start;
  logic                ap_ready;
  logic                ap_done;
  logic                ap_idle;
  logic [NUM_PROC-1:0] proc_block;
  logic                busy;
  logic [FRAME_W-1:0]  frame_cnt;
  logic                deadlock;
  logic [IDX_W-1:0]    deadlock_idx;
`ifdef STEREO_SEQ_STATS_EN
  logic [31:0]         max_frame_cycles;
`endif

  modport master (
`ifdef STEREO_SEQ_STATS_EN
    output max_frame_cycles,
`endif
    input  run, frame_req, wdog_limit, clear_dl, ap_ready, ap_done, ap_idle, proc_block,
    output ap_start, busy, frame_cnt, deadlock, deadlock_idx
  );

  modport slave (
`ifdef STEREO_SEQ_STATS_EN
    input  max_frame_cycles,
`endif
    output run, frame_req, wdog_limit, clear_dl, ap_ready, ap_done, ap_idle, proc_block,
    input  ap_start, busy, frame_cnt, deadlock, deadlock_idx
  );

endinterface

// File: rtl/stereo_seq_watchdog.sv
// Stall counter for the frame sequencer: counts consecutive blocked cycles, flags expiry
// against the programmed limit and reports the lowest blocked process index.
module stereo_seq_watchdog #(
  parameter int unsigned NUM_PROC = 6,
  parameter int unsigned WDOG_W   = 20,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_active,
  input  logic [WDOG_W-1:0]   i_limit,
  input  logic [NUM_PROC-1:0] i_block,
  input  logic                i_done,
  output logic                o_expire,
  output logic [IDX_W-1:0]    o_low_idx
);

  logic [WDOG_W-1:0] r_cnt;
  logic [WDOG_W:0]   w_cnt_inc;
  logic              w_stall;

  // A completing frame is never a stall, so ap_done always beats expiry.
  assign w_stall   = i_active && (i_limit != '0) && (|i_block) && !i_done;
  assign w_cnt_inc = (WDOG_W + 1)'(r_cnt) + (WDOG_W + 1)'(1);
  assign o_expire  = w_stall && (w_cnt_inc == {1'b0, i_limit});

  always_ff @(posedge clock) begin
    if (reset || !w_stall) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + WDOG_W'(1);
    end
  end

  always_comb begin
    o_low_idx = '0;
    for (int i = int'(NUM_PROC) - 1; i >= 0; i--) begin
      if (i_block[i]) o_low_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/stereo_frame_sequencer.sv
// Frame-level ap_ctrl_hs sequencer with frame counter and stall watchdog for the LBM core.
// Define STEREO_SEQ_STATS_EN to add the max_frame_cycles statistic.
module stereo_frame_sequencer
  import stereo_seq_pkg::*;
#(
  parameter int unsigned NUM_PROC = DEF_NUM_PROC,
  parameter int unsigned WDOG_W   = DEF_WDOG_W,
  parameter int unsigned FRAME_W  = DEF_FRAME_W
) (
  input logic                      clock,
  input logic                      reset,
  stereo_frame_sequencer_if.master bus
);

  localparam int unsigned IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

  seq_state_e         r_state;
  seq_state_e         w_state_d;
  logic               r_ap_start;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_deadlock;
  logic [IDX_W-1:0]   r_deadlock_idx;

  logic               w_active;
  logic               w_expire;
  logic               w_alarm;
  logic               w_frame_done;
  logic               w_deadlock_d;
  logic [IDX_W-1:0]   w_idx_d;
  logic [IDX_W-1:0]   w_low_idx;

  assign w_active = (r_state == StStart) || (r_state == StRun);

  stereo_seq_watchdog #(
    .NUM_PROC (NUM_PROC),
    .WDOG_W   (WDOG_W),
    .IDX_W    (IDX_W)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_active  (w_active),
    .i_limit   (bus.wdog_limit),
    .i_block   (bus.proc_block),
    .i_done    (bus.ap_done),
    .o_expire  (w_expire),
    .o_low_idx (w_low_idx)
  );

  always_comb begin
    w_state_d    = r_state;
    w_frame_done = 1'b0;
    w_alarm      = 1'b0;
    w_deadlock_d = r_deadlock;
    w_idx_d      = r_deadlock_idx;
    case (r_state)
      StIdle: begin
        if (!r_deadlock && (bus.run || bus.frame_req) && bus.ap_idle) w_state_d = StStart;
      end
      StStart: begin
        // Handshake is held until ap_ready regardless of run.
        if (bus.ap_ready && bus.ap_done) begin
          w_frame_done = 1'b1;
          w_state_d    = StIdle;
        end else if (w_expire) begin
          w_alarm = 1'b1;
        end else if (bus.ap_ready) begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (bus.ap_done) begin
          w_frame_done = 1'b1;
          w_state_d    = bus.run ? StStart : StIdle;
        end else if (w_expire) begin
          w_alarm = 1'b1;
        end
      end
      StHalt: begin
        if (bus.clear_dl) begin
          w_state_d    = StIdle;
          w_deadlock_d = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_alarm) begin
      w_state_d    = StHalt;
      w_deadlock_d = 1'b1;
      w_idx_d      = w_low_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= StIdle;
      r_ap_start     <= 1'b0;
      r_frame_cnt    <= '0;
      r_deadlock     <= 1'b0;
      r_deadlock_idx <= '0;
    end else begin
      r_state        <= w_state_d;
      r_ap_start     <= (w_state_d == StStart);
      r_deadlock     <= w_deadlock_d;
      r_deadlock_idx <= w_idx_d;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
    end
  end

  assign bus.ap_start     = r_ap_start;
  assign bus.busy         = w_active;
  assign bus.frame_cnt    = r_frame_cnt;
  assign bus.deadlock     = r_deadlock;
  assign bus.deadlock_idx = r_deadlock_idx;

`ifdef STEREO_SEQ_STATS_EN
  logic [31:0] r_cyc;
  logic [31:0] r_max_cyc;
  logic [31:0] w_len;

  // Frame length is inclusive of both the first START cycle and the ap_done cycle.
  assign w_len = (r_cyc == '1) ? r_cyc : r_cyc + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cyc     <= '0;
      r_max_cyc <= '0;
    end else begin
      if ((w_state_d == StStart) && (r_state != StStart)) begin
        r_cyc <= '0;
      end else if (w_active && (r_cyc != '1)) begin
        r_cyc <= r_cyc + 32'd1;
      end
      if (w_frame_done && (w_len > r_max_cyc)) r_max_cyc <= w_len;
    end
  end

  assign bus.max_frame_cycles = r_max_cyc;
`endif

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// Self-checking bench for stereo_frame_sequencer: vector table, directed corner sequences
// and a randomized run against a behavioural model.
module tb_stereo_frame_sequencer;
  import stereo_seq_pkg::*;

  localparam int unsigned NP = DEF_NUM_PROC;
  localparam int unsigned WW = DEF_WDOG_W;
  localparam int unsigned FW = DEF_FRAME_W;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  stereo_frame_sequencer_if #(.NUM_PROC(NP), .WDOG_W(WW), .FRAME_W(FW)) u_if ();
  stereo_frame_sequencer_if #(.NUM_PROC(NP), .WDOG_W(WW), .FRAME_W(4))  u_if4 ();

  stereo_frame_sequencer #(.NUM_PROC(NP), .WDOG_W(WW), .FRAME_W(FW)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.master)
  );

  // Narrow-counter copy sharing all inputs, used for the wrap check.
  stereo_frame_sequencer #(.NUM_PROC(NP), .WDOG_W(WW), .FRAME_W(4)) u_dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (u_if4.master)
  );

  assign u_if4.run        = u_if.run;
  assign u_if4.frame_req  = u_if.frame_req;
  assign u_if4.wdog_limit = u_if.wdog_limit;
  assign u_if4.clear_dl   = u_if.clear_dl;
  assign u_if4.ap_ready   = u_if.ap_ready;
  assign u_if4.ap_done    = u_if.ap_done;
  assign u_if4.ap_idle    = u_if.ap_idle;
  assign u_if4.proc_block = u_if.proc_block;

  typedef struct {
    logic        run, req, rdy, done, idle, clr;
    logic        e_start, e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic run, req, rdy, done, idle, clr, s, b,
                              input logic [15:0] c);
    vec_t v;
    v.run = run; v.req = req; v.rdy = rdy; v.done = done; v.idle = idle; v.clr = clr;
    v.e_start = s; v.e_busy = b; v.e_cnt = c;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    u_if.run        = 1'b0;
    u_if.frame_req  = 1'b0;
    u_if.wdog_limit = '0;
    u_if.clear_dl   = 1'b0;
    u_if.ap_ready   = 1'b0;
    u_if.ap_done    = 1'b0;
    u_if.ap_idle    = 1'b1;
    u_if.proc_block = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ap_start"}, 32'(u_if.ap_start), 0);
    chk({tag, ".busy"}, 32'(u_if.busy), 0);
    chk({tag, ".frame_cnt"}, 32'(u_if.frame_cnt), 0);
    chk({tag, ".deadlock"}, 32'(u_if.deadlock), 0);
    chk({tag, ".deadlock_idx"}, 32'(u_if.deadlock_idx), 0);
`ifdef STEREO_SEQ_STATS_EN
    chk({tag, ".max_frame_cycles"}, u_if.max_frame_cycles, 0);
`endif
  endtask

  // Runs one frame from IDLE into RUN (frame_req, then ready on the first START cycle).
  task automatic enter_run();
    u_if.frame_req = 1'b1;
    tick();
    u_if.frame_req = 1'b0;
    u_if.ap_ready  = 1'b1;
    tick();
    u_if.ap_ready  = 1'b0;
  endtask

  // Behavioural model: handshake pending / core running / halted, plus stall length.
  bit m_req, m_act, m_halt, m_dl;
  int m_frames, m_stall, m_idx;

  function automatic int lowest(input logic [NP-1:0] b);
    for (int i = 0; i < int'(NP); i++) if (b[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    bit busy, fin, expire;
    if (reset) begin
      m_req = 0; m_act = 0; m_halt = 0; m_dl = 0; m_frames = 0; m_stall = 0; m_idx = 0;
      return;
    end
    busy = m_req || m_act;
    fin  = (m_req && u_if.ap_ready && u_if.ap_done) || (m_act && u_if.ap_done);
    if (busy && u_if.wdog_limit != 0 && u_if.proc_block != 0 && !u_if.ap_done) m_stall++;
    else m_stall = 0;
    expire = (m_stall != 0) && (m_stall == int'(u_if.wdog_limit));
    if (m_halt) begin
      if (u_if.clear_dl) begin m_halt = 0; m_dl = 0; end
    end else if (fin) begin
      m_frames++;
      m_req = m_act && u_if.run;
      m_act = 0;
    end else if (busy && expire) begin
      m_halt = 1; m_dl = 1; m_idx = lowest(u_if.proc_block); m_req = 0; m_act = 0;
    end else if (m_req && u_if.ap_ready) begin
      m_req = 0; m_act = 1;
    end else if (!busy && !m_dl && (u_if.run || u_if.frame_req) && u_if.ap_idle) begin
      m_req = 1;
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    //         run req rdy dn idl clr  st bsy cnt
    tbl[0]  = mk(0, 1, 0, 0, 1, 0,  1, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 0,  1, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0,  1, 1, 0);
    tbl[3]  = mk(0, 0, 1, 0, 1, 0,  0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1, 0,  0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 1, 1, 0,  0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 1, 0,  0, 0, 1);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 1);
    tbl[8]  = mk(1, 0, 0, 0, 1, 0,  1, 1, 1);
    tbl[9]  = mk(1, 0, 1, 1, 1, 0,  0, 0, 2);
    tbl[10] = mk(1, 0, 0, 0, 1, 0,  1, 1, 2);
    tbl[11] = mk(0, 0, 0, 0, 1, 0,  1, 1, 2);
    tbl[12] = mk(0, 0, 1, 0, 1, 0,  0, 1, 2);
    tbl[13] = mk(0, 0, 0, 1, 1, 0,  0, 0, 3);
    tbl[14] = mk(0, 0, 0, 0, 1, 1,  0, 0, 3);
    tbl[15] = mk(0, 0, 0, 1, 1, 0,  0, 0, 3);

    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 16; i++) begin
      u_if.run = tbl[i].run;   u_if.frame_req = tbl[i].req; u_if.ap_ready = tbl[i].rdy;
      u_if.ap_done = tbl[i].done; u_if.ap_idle = tbl[i].idle; u_if.clear_dl = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d.ap_start", i), 32'(u_if.ap_start), 32'(tbl[i].e_start));
      chk($sformatf("vec%0d.busy", i), 32'(u_if.busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d.frame_cnt", i), 32'(u_if.frame_cnt), 32'(tbl[i].e_cnt));
    end

    // Continuous mode: four frames, ap_start back one cycle after each ap_done.
    do_reset();
    u_if.run = 1'b1;
    tick();
    chk("cont.first_start", 32'(u_if.ap_start), 1);
    for (int f = 0; f < 4; f++) begin
      u_if.ap_ready = 1'b1;
      tick();
      u_if.ap_ready = 1'b0;
      chk($sformatf("cont%0d.run_start", f), 32'(u_if.ap_start), 0);
      tick();
      tick();
      if (f == 3) u_if.run = 1'b0;
      u_if.ap_done = 1'b1;
      tick();
      u_if.ap_done = 1'b0;
      chk($sformatf("cont%0d.restart", f), 32'(u_if.ap_start), (f < 3) ? 1 : 0);
      chk($sformatf("cont%0d.frame_cnt", f), 32'(u_if.frame_cnt), 32'(f + 1));
    end
    chk("cont.busy_end", 32'(u_if.busy), 0);

    // Deadlock: limit 50, alarm exactly 50 cycles into the stall, lowest index 2.
    do_reset();
    u_if.wdog_limit = WW'(50);
    enter_run();
    u_if.proc_block = 6'b010100;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (c == 49) chk("dl.before", 32'(u_if.deadlock), 0);
    end
    chk("dl.alarm", 32'(u_if.deadlock), 1);
    chk("dl.idx", 32'(u_if.deadlock_idx), 2);
    chk("dl.ap_start", 32'(u_if.ap_start), 0);
    chk("dl.busy", 32'(u_if.busy), 0);
    u_if.frame_req = 1'b1;
    tick();
    u_if.frame_req = 1'b0;
    tick();
    chk("dl.req_ignored", 32'(u_if.ap_start), 0);
    chk("dl.still_set", 32'(u_if.deadlock), 1);
    u_if.clear_dl = 1'b1;
    tick();
    u_if.clear_dl = 1'b0;
    u_if.proc_block = '0;
    chk("dl.cleared", 32'(u_if.deadlock), 0);
    chk("dl.idx_held", 32'(u_if.deadlock_idx), 2);
    enter_run();
    u_if.ap_done = 1'b1;
    tick();
    u_if.ap_done = 1'b0;
    chk("dl.next_frame", 32'(u_if.frame_cnt), 1);

    // Reset in the middle of RUN clears everything on the next cycle.
    enter_run();
    chk("rst.in_run", 32'(u_if.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("rst_mid");

    // Race: ap_done on the 10th stall cycle wins over expiry.
    do_reset();
    u_if.wdog_limit = WW'(10);
    enter_run();
    u_if.proc_block = 6'b100000;
    repeat (9) tick();
    u_if.ap_done = 1'b1;
    tick();
    u_if.ap_done = 1'b0;
    u_if.proc_block = '0;
    chk("race.deadlock", 32'(u_if.deadlock), 0);
    chk("race.frame_cnt", 32'(u_if.frame_cnt), 1);
    chk("race.busy", 32'(u_if.busy), 0);

    // Same limit without ap_done: alarm on the 10th cycle, index 3; also in START.
    u_if.frame_req = 1'b1;
    tick();
    u_if.frame_req = 1'b0;
    u_if.proc_block = 6'b101000;
    repeat (9) tick();
    chk("start_dl.before", 32'(u_if.deadlock), 0);
    chk("start_dl.holding", 32'(u_if.ap_start), 1);
    tick();
    chk("start_dl.alarm", 32'(u_if.deadlock), 1);
    chk("start_dl.idx", 32'(u_if.deadlock_idx), 3);

    // Watchdog disabled with limit 0.
    do_reset();
    enter_run();
    u_if.proc_block = 6'b000001;
    repeat (100) tick();
    chk("nolimit.deadlock", 32'(u_if.deadlock), 0);
    chk("nolimit.busy", 32'(u_if.busy), 1);

    // Wrap: ready+done in START gives one frame per two cycles; 17 frames.
    do_reset();
    u_if.run = 1'b1; u_if.ap_ready = 1'b1; u_if.ap_done = 1'b1;
    repeat (34) tick();
    chk("wrap.cnt16", 32'(u_if.frame_cnt), 17);
    chk("wrap.cnt4", 32'(u_if4.frame_cnt), 1);

    // Randomized run against the model.
    do_reset();
    model_step();
    u_if.wdog_limit = WW'(4);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 39) == 0) u_if.run = ~u_if.run;
      u_if.frame_req = ($urandom_range(0, 7) == 0);
      u_if.ap_ready  = ($urandom_range(0, 2) == 0);
      u_if.ap_done   = ($urandom_range(0, 4) == 0);
      u_if.ap_idle   = ($urandom_range(0, 5) != 0);
      u_if.clear_dl  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) u_if.proc_block = $urandom_range(0, 1) ? NP'($urandom) : '0;
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 3))
          0:       u_if.wdog_limit = '0;
          1:       u_if.wdog_limit = WW'(2);
          2:       u_if.wdog_limit = WW'(4);
          default: u_if.wdog_limit = WW'(7);
        endcase
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
      model_step();
      chk("rnd.ap_start", 32'(u_if.ap_start), 32'(m_req));
      chk("rnd.busy", 32'(u_if.busy), 32'(m_req || m_act));
      chk("rnd.frame_cnt", 32'(u_if.frame_cnt), 32'(m_frames[15:0]));
      chk("rnd.frame_cnt4", 32'(u_if4.frame_cnt), 32'(m_frames[3:0]));
      chk("rnd.deadlock", 32'(u_if.deadlock), 32'(m_dl));
      chk("rnd.deadlock_idx", 32'(u_if.deadlock_idx), 32'(m_idx));
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stereo_frame_sequencer.md
# stereo_frame_sequencer

Frame-level controller for the stereo LBM dataflow core, placed between the system control logic and the core's ap_ctrl_hs port. It issues one ap_start handshake per frame (continuous or single-shot), counts completed frames, and watches the per-process deadlock-monitor block outputs. A stall that persists past a programmable window raises a sticky deadlock alarm and reports the lowest blocked process index.

## Interface
- NUM_PROC, 6, number of per-process deadlock-monitor `block` inputs.
- WDOG_W, 20, watchdog counter width.
- FRAME_W, 16, frame counter width.

- clock  in  1  core clock; reset reset, synchronous, active-high; clock clock.
- reset  in  1  synchronous, active-high.
- run  in  1  level; 1 = continuous frames.
- frame_req  in  1  one-cycle pulse; requests one frame while run=0.
- wdog_limit  in  WDOG_W  stall cycles before alarm; 0 disables the watchdog.
- clear_dl  in  1  one-cycle pulse; clears the deadlock alarm.
- ap_start  out  1  to core.
- ap_ready  in  1  from core.
- ap_done  in  1  from core.
- ap_idle  in  1  from core.
- proc_block  in  NUM_PROC  deadlock-monitor `block` outputs.
- busy  out  1  high in START/RUN.
- frame_cnt  out  FRAME_W  completed frames; wraps.
- deadlock  out  1  sticky alarm.
- deadlock_idx  out  $clog2(NUM_PROC)  lowest blocked index, captured at alarm.

## Operation
- States: IDLE, START, RUN, HALT.
- IDLE: if deadlock=0 and (run=1, or frame_req=1) and ap_idle=1 -> START. frame_req is ignored outside IDLE. It is ignored in IDLE when deadlock=1.
- START: ap_start=1. When ap_ready=1 -> RUN, or -> IDLE if ap_done=1 in the same cycle (frame_cnt+1).
- RUN: on ap_done=1 -> frame_cnt+1. Then -> START if run=1, else -> IDLE.
- Watchdog: active in START/RUN when wdog_limit!=0.
  - Counter increments each cycle |proc_block=1 and ap_done=0.
  - Clears on any cycle with |proc_block=0 or ap_done=1.
  - Saturates at all-ones.
  - When counter+1 == wdog_limit: deadlock<=1, deadlock_idx<=lowest set bit of proc_block, state -> HALT.
- Simultaneous ap_done and expiry: ap_done wins. The frame is counted, no alarm, counter clears.
- HALT: ap_start=0. Stays in HALT until clear_dl=1, then -> IDLE, deadlock<=0, counter cleared; deadlock_idx holds its last value.
- clear_dl outside HALT has no effect.
- run deasserted in START: the handshake still completes (ap_start is never withdrawn before ap_ready).

## Timing
- Reset values: ap_start=0, busy=0, frame_cnt=0, deadlock=0, deadlock_idx=0, state IDLE, watchdog=0. Reset mid-frame aborts immediately; the core is not drained.
- ap_start is registered and rises the cycle after the IDLE->START decision.
- ap_done -> frame_cnt update: 1 cycle.
- Continuous mode: ap_start re-asserts the cycle after ap_done (1-cycle gap).
- Alarm: deadlock rises exactly wdog_limit cycles after the first cycle of a continuous stall.
- frame_cnt wraps from 2^FRAME_W-1 to 0 with no flag.

## Configuration
- STEREO_SEQ_STATS_EN defined: adds output max_frame_cycles [31:0], the largest START-entry-to-ap_done cycle count seen since reset. It saturates at all-ones and clears on reset only.
- Undefined: the port and its counters are absent; all other behaviour is identical.

## Structure
- Package stereo_seq_pkg holds the state enum (IDLE/START/RUN/HALT) and default widths (NUM_PROC, WDOG_W, FRAME_W).
- One sub-module, stereo_seq_watchdog, implements the stall counter, the expiry compare, and the lowest-index priority encoder.

## Test plan
- Single shot: run=0, frame_req pulse, core ready after 3 cycles and done after 100 -> one ap_start pulse held 3 cycles, frame_cnt=1, then IDLE with busy=0.
- Continuous: run=1 for 4 frames -> ap_start re-asserts 1 cycle after each ap_done; frame_cnt=4.
- Deadlock: wdog_limit=50, proc_block=6'b010100 held -> deadlock=1 after exactly 50 cycles, deadlock_idx=2, ap_start=0. A frame_req while deadlock=1 is ignored. clear_dl -> IDLE.
- Race: wdog_limit=10, ap_done arrives on the 10th stall cycle -> no alarm, frame_cnt increments.
- Ready+done same cycle in START -> frame_cnt+1, no RUN visit. Wrap check: FRAME_W=4 and 17 frames -> frame_cnt=1.
- Reset mid-RUN -> all outputs 0 on the next cycle. With STEREO_SEQ_STATS_EN defined, max_frame_cycles=0 after reset.
